cmt_nch: RTL and testbench
==========================

Name: cmt_nch

Overview:
- Parametrised N-channel compare match timer. Successor to the fixed 2-channel CMT.
- Each channel has:
  - a prescaler selectable as clk/8, /32, /128 or /512;
  - a CW-bit compare counter;
  - periodic or one-shot mode;
  - a sticky status flag with per-channel interrupt enable.
- Sits behind the peripheral register block. That block drives start, config and counter writes, and reads back counts and status; irq_o goes to the interrupt controller.

Parameters:
- NCH, 2, number of channels (1..8).
- CW, 16, compare counter / constant width (4..32).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Synchronous, active-low.
- str_i  in  NCH  per-channel start/run enable.
- cks_i  in  2*NCH  clock select, channel n at [2n+1:2n]: 00 /8, 01 /32, 10 /128, 11 /512.
- mode_i  in  NCH  0 periodic, 1 one-shot.
- const_i  in  NCH*CW  compare constant, channel n at [CW*n+CW-1:CW*n].
- set_cnt_i  in  NCH  load strobe for the compare counter.
- wdata_cnt_i  in  NCH*CW  load value, same packing as const_i.
- ie_i  in  NCH  interrupt enable per channel.
- clr_i  in  NCH  write-1-to-clear strobe for sts_o.
- cmf_o  out  NCH  one-cycle match pulse.
- sts_o  out  NCH  sticky match status.
- cnt_o  out  NCH*CW  current compare counter values.
- irq_o  out  1  OR over all channels of (sts_o & ie_i).

Behaviour:
- Reset (rst_n low at a clk edge), per channel:
  - psc=0, cnt=1, cmf_o=0, sts_o=0, armed=1, str_d=0.
  - irq_o=0.
  - Reset asserted mid-count abandons the count; no pulse is produced.
- Channels are fully independent. All state is registered on clk.
- div: 8/32/128/512 from cks_i, decoded every cycle.
- run = str_i & armed.
- Tick (combinational) = (psc >= div) & run & ~set_cnt_i.
  - The >= comparison makes a cks_i change mid-count safe: a prescaler above the new divider ticks immediately and never wraps.
- Prescaler update, priority order:
  - set_cnt_i → psc:=1.
  - tick → psc:=1.
  - run → psc+1.
  - otherwise hold.
  - Prescaler width is 10 bits.
- Match = tick & (cnt == const).
- Compare counter update, priority order:
  - set_cnt_i → cnt:=wdata.
  - match → cnt:=1.
  - tick → cnt+1, modulo 2^CW.
  - otherwise hold.
- Resulting period is const ticks. const=0 gives 2^CW ticks: the counter wraps to 0 and matches there. set_cnt_i suppresses match in its cycle.
- cmf_o is registered match: high exactly one cycle, in the cycle after the match clock edge.
- sts_o:
  - set on match, cleared by clr_i bit.
  - Simultaneous match and clr: set wins.
- irq_o is registered, one cycle after sts_o / ie_i change.
- One-shot mode (mode_i=1):
  - match clears armed; the channel stops with cnt=1 and psc held.
  - armed is set again by a str_i 0→1 edge (str_d is the registered str_i) or by set_cnt_i.
  - Holding str_i high does not restart the channel.
  - Changing mode_i to 0 while disarmed does not re-arm; an edge or load is required.
- Periodic mode: armed is never cleared.
- str_i low freezes psc and cnt; cnt_o keeps reading the frozen value.
- First tick after start: with psc=0 at start, the first tick occurs div clocks after str_i is first sampled high. Later ticks are every div clocks.

Test Plan:
- Periodic, NCH=2, ch0 cks=00, const=3, str0 high from edge 0 → cmf_o[0] pulses 24 clocks after start, then every 24; cnt_o[0] sequence 1,2,3,1; ch1 idle, all ch1 outputs stay 0 / cnt=1.
- One-shot, ch1 cks=00, const=2, mode=1, str held high → single cmf_o[1] at 16 clocks, none after 200 clocks; drop str one cycle and raise again → next pulse 16 clocks later.
- Load, set_cnt0 with wdata=0x0005 in the same cycle as a would-be match (const=5) → no cmf that cycle; cnt_o[0]=5; the next tick matches and cmf_o fires.
- Wrap, CW=4, const=0, cks=00 → cnt runs 1..15,0, and cmf fires every 128 clocks.
- cks change mid-count: /512 with psc≈300, switch to /8 → tick on the next cycle, then every 8 clocks; the prescaler never exceeds 512.
- Status/irq: ie0=1; a match sets sts_o[0] and irq_o one cycle later; clr_i[0] pulsed on the same cycle as the next match leaves sts_o[0]=1; a lone clr clears it and irq_o falls. rst_n low mid-count for 1 cycle → all outputs reset, cnt=1.

Source files
------------

// File: rtl/cmt_nch.sv
// N-channel compare match timer: per-channel prescaler, compare counter,
// periodic or one-shot operation, sticky status and a shared interrupt line.
module cmt_nch #(
    parameter int unsigned NCH = 2,
    parameter int unsigned CW  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    str_i,
    input  logic [2*NCH-1:0]  cks_i,
    input  logic [NCH-1:0]    mode_i,
    input  logic [NCH*CW-1:0] const_i,
    input  logic [NCH-1:0]    set_cnt_i,
    input  logic [NCH*CW-1:0] wdata_cnt_i,
    input  logic [NCH-1:0]    ie_i,
    input  logic [NCH-1:0]    clr_i,
    output logic [NCH-1:0]    cmf_o,
    output logic [NCH-1:0]    sts_o,
    output logic [NCH*CW-1:0] cnt_o,
    output logic              irq_o
);

    localparam int unsigned PW = 10;

    logic irq_q;

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        logic [PW-1:0] psc_q;
        logic [PW-1:0] div_c;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cmp_c;
        logic [CW-1:0] wdata_c;
        logic          cmf_q;
        logic          sts_q;
        logic          armed_q;
        logic          str_d_q;
        logic          run_c;
        logic          tick_c;
        logic          match_c;
        logic          rearm_c;

        // Divider decode and tick/match qualification for this channel.
        always_comb begin
            div_c = PW'(8);
            case (cks_i[2*n +: 2])
                2'b01:   div_c = PW'(32);
                2'b10:   div_c = PW'(128);
                2'b11:   div_c = PW'(512);
                default: div_c = PW'(8);
            endcase
            cmp_c   = const_i[CW*n +: CW];
            wdata_c = wdata_cnt_i[CW*n +: CW];
            run_c   = str_i[n] & armed_q;
            // >= keeps a prescaler left above a newly selected smaller divider from wrapping
            tick_c  = (psc_q >= div_c) & run_c & ~set_cnt_i[n];
            match_c = tick_c & (cnt_q == cmp_c);
            rearm_c = set_cnt_i[n] | (str_i[n] & ~str_d_q);
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                psc_q   <= '0;
                cnt_q   <= CW'(1);
                cmf_q   <= 1'b0;
                sts_q   <= 1'b0;
                armed_q <= 1'b1;
                str_d_q <= 1'b0;
            end else begin
                if (set_cnt_i[n]) begin
                    psc_q <= PW'(1);
                    cnt_q <= wdata_c;
                end else if (tick_c) begin
                    psc_q <= PW'(1);
                    cnt_q <= match_c ? CW'(1) : cnt_q + CW'(1);
                end else if (run_c) begin
                    psc_q <= psc_q + PW'(1);
                end
                cmf_q <= match_c;
                if (match_c) begin
                    sts_q <= 1'b1;
                end else if (clr_i[n]) begin
                    sts_q <= 1'b0;
                end
                // A restart event takes precedence over a one-shot disarm in the same cycle.
                if (rearm_c) begin
                    armed_q <= 1'b1;
                end else if (match_c && mode_i[n]) begin
                    armed_q <= 1'b0;
                end
                str_d_q <= str_i[n];
            end
        end

        assign cmf_o[n]            = cmf_q;
        assign sts_o[n]            = sts_q;
        assign cnt_o[CW*n +: CW]   = cnt_q;
    end

    // Interrupt follows the registered status one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(sts_o & ie_i);
        end
    end

    assign irq_o = irq_q;

endmodule

// File: tb/tb_cmt_nch.sv
// Scoreboard bench for cmt_nch: a behavioural per-channel model predicts every
// cycle's outputs, and a separate monitor compares them against the DUT.
module tb_cmt_nch;

    localparam int unsigned NCH = 3;
    localparam int unsigned CW  = 6;

    typedef struct packed {
        logic [NCH-1:0]    cmf;
        logic [NCH-1:0]    sts;
        logic [NCH*CW-1:0] cnt;
        logic              irq;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    str;
    logic [2*NCH-1:0]  cks;
    logic [NCH-1:0]    mode;
    logic [NCH*CW-1:0] cst;
    logic [NCH-1:0]    set_cnt;
    logic [NCH*CW-1:0] wdata;
    logic [NCH-1:0]    ie;
    logic [NCH-1:0]    clr;
    logic [NCH-1:0]    cmf;
    logic [NCH-1:0]    sts;
    logic [NCH*CW-1:0] cnt;
    logic              irq;

    cmt_nch #(.NCH(NCH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .str_i(str), .cks_i(cks), .mode_i(mode),
        .const_i(cst), .set_cnt_i(set_cnt), .wdata_cnt_i(wdata), .ie_i(ie),
        .clr_i(clr), .cmf_o(cmf), .sts_o(sts), .cnt_o(cnt), .irq_o(irq)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    int   n_cmf = 0;
    exp_t q[$];

    // Reference model state, one entry per channel.
    int m_psc[NCH];
    int m_cnt[NCH];
    bit m_armed[NCH];
    bit m_strd[NCH];
    bit m_cmf[NCH];
    bit m_sts[NCH];
    bit m_irq;

    function automatic int div_of(int ch);
        return 8 << (2 * int'(cks[2*ch +: 2]));
    endfunction

    function automatic bit tick_now(int ch);
        return str[ch] && m_armed[ch] && !set_cnt[ch] && (m_psc[ch] >= div_of(ch));
    endfunction

    function automatic bit match_next(int ch);
        return rst_n && tick_now(ch) && (m_cnt[ch] == int'(cst[CW*ch +: CW]));
    endfunction

    task automatic step_model();
        exp_t e;
        bit   nirq;
        bit   t;
        bit   mt;
        nirq = 1'b0;
        for (int ch = 0; ch < NCH; ch++) if (m_sts[ch] && ie[ch]) nirq = 1'b1;
        for (int ch = 0; ch < NCH; ch++) begin
            if (!rst_n) begin
                m_psc[ch] = 0; m_cnt[ch] = 1; m_cmf[ch] = 0;
                m_sts[ch] = 0; m_armed[ch] = 1; m_strd[ch] = 0;
            end else begin
                t  = tick_now(ch);
                mt = t && (m_cnt[ch] == int'(cst[CW*ch +: CW]));
                if (set_cnt[ch]) begin
                    m_psc[ch] = 1;
                    m_cnt[ch] = int'(wdata[CW*ch +: CW]);
                end else if (t) begin
                    m_psc[ch] = 1;
                    m_cnt[ch] = mt ? 1 : (m_cnt[ch] + 1) % (1 << CW);
                end else if (str[ch] && m_armed[ch]) begin
                    m_psc[ch] = m_psc[ch] + 1;
                end
                m_cmf[ch] = mt;
                if (mt) m_sts[ch] = 1;
                else if (clr[ch]) m_sts[ch] = 0;
                if (set_cnt[ch] || (str[ch] && !m_strd[ch])) m_armed[ch] = 1;
                else if (mt && mode[ch]) m_armed[ch] = 0;
                m_strd[ch] = str[ch];
            end
        end
        m_irq = rst_n ? nirq : 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            e.cmf[ch] = m_cmf[ch];
            e.sts[ch] = m_sts[ch];
            e.cnt[CW*ch +: CW] = CW'(m_cnt[ch]);
        end
        e.irq = m_irq;
        q.push_back(e);
    endtask

    // Predict the coming edge with the current inputs, then advance to the next falling edge.
    task automatic cyc(int n);
        repeat (n) begin
            step_model();
            @(negedge clk);
        end
    endtask

    task automatic wait_match(int ch, int budget, string name);
        for (int i = 0; i < budget && !match_next(ch); i++) cyc(1);
        tests++;
        if (!match_next(ch)) begin
            fails++;
            $display("FAIL %s: no match on ch%0d within %0d cycles (psc=%0d cnt=%0d)",
                     name, ch, budget, m_psc[ch], m_cnt[ch]);
        end
    endtask

    // Monitor: every output cycle pops one expectation.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if (|cmf) n_cmf++;
            if ({cmf, sts, cnt, irq} !== e) begin
                fails++;
                $display("FAIL cycle t=%0t: cmf=%h/%h sts=%h/%h cnt=%h/%h irq=%b/%b (got/exp)",
                         $time, cmf, e.cmf, sts, e.sts, cnt, e.cnt, irq, e.irq);
            end
        end
    end

    initial begin
        int r;
        int len;
        rst_n = 1'b0; str = '0; cks = '0; mode = '0; cst = '0;
        set_cnt = '0; wdata = '0; ie = '0; clr = '0;
        @(negedge clk);
        cyc(3);
        rst_n = 1'b1;

        // Periodic ch0, /8, const 3; ch1 and ch2 idle.
        cst[0 +: CW] = CW'(3); str[0] = 1'b1; ie[0] = 1'b1;
        cyc(100);

        // One-shot ch1, /8, const 2, held start then a one-cycle drop.
        cst[CW +: CW] = CW'(2); mode[1] = 1'b1; str[1] = 1'b1;
        cyc(200);
        str[1] = 1'b0; cyc(1); str[1] = 1'b1;
        cyc(40);
        str[1] = 1'b0;

        // Load coinciding with a would-be match on ch0.
        cst[0 +: CW] = CW'(5);
        wait_match(0, 300, "load_setup");
        set_cnt[0] = 1'b1; wdata[0 +: CW] = CW'(5);
        cyc(1);
        set_cnt[0] = 1'b0;
        cyc(60);

        // Wrap on ch2 with const 0: full 2^CW ticks per match.
        cst[2*CW +: CW] = '0; str[2] = 1'b1;
        cyc(1100);
        str[2] = 1'b0;

        // Divider change mid-count on ch0: /512 down to /8.
        cks[1:0] = 2'b11; cst[0 +: CW] = CW'(63);
        for (int i = 0; i < 700 && m_psc[0] < 300; i++) cyc(1);
        cks[1:0] = 2'b00;
        cyc(40);

        // Status and interrupt on ch0: clr racing a match, then a lone clr.
        cst[0 +: CW] = CW'(1);
        set_cnt[0] = 1'b1; wdata[0 +: CW] = CW'(1);
        cyc(1);
        set_cnt[0] = 1'b0;
        wait_match(0, 100, "sts_first");
        cyc(3);
        wait_match(0, 100, "sts_race");
        clr[0] = 1'b1; cyc(1); clr[0] = 1'b0;
        cyc(3);
        clr[0] = 1'b1; cyc(1); clr[0] = 1'b0;
        cyc(3);

        // Single-cycle reset in the middle of counting.
        str = '1;
        cyc(13);
        rst_n = 1'b0; cyc(1); rst_n = 1'b1;
        cyc(30);

        // Randomized segments.
        for (int s = 0; s < 280; s++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                str[ch]  = ($urandom_range(0, 9) != 0);
                r        = int'($urandom_range(0, 9));
                cks[2*ch +: 2] = 2'(r < 5 ? 0 : (r < 8 ? 1 : (r < 9 ? 2 : 3)));
                mode[ch] = 1'($urandom_range(0, 1));
                cst[CW*ch +: CW] = ($urandom_range(0, 3) == 0) ? CW'($urandom)
                                                                : CW'($urandom_range(0, 6));
                ie[ch]   = 1'($urandom_range(0, 1));
            end
            len = int'($urandom_range(20, 150));
            repeat (len) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    set_cnt[ch] = ($urandom_range(0, 49) == 0);
                    wdata[CW*ch +: CW] = CW'($urandom_range(0, 7));
                    clr[ch] = ($urandom_range(0, 15) == 0);
                    if ($urandom_range(0, 99) == 0) str[ch] = ~str[ch];
                end
                rst_n = ($urandom_range(0, 999) != 0);
                cyc(1);
            end
        end
        rst_n = 1'b1; set_cnt = '0; clr = '0;
        cyc(2);

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        tests++;
        if (n_cmf == 0) begin
            fails++;
            $display("FAIL pulses: saw %0d cmf cycles, required more than 0", n_cmf);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
